// File: rtl/ldo_rail_sequencer.sv
// Power-up/down sequencer for the IO, Analog and Logic LDO rails with power-good supervision.
// Define LDO_SEQ_RETRY_EN to allow one automatic retry after a power-up fault.
module ldo_rail_sequencer #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned STEP_DLY   = 20,
  parameter int unsigned PG_TIMEOUT = 50,
  parameter int unsigned OFF_DLY    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_fault,
  input  logic       pg_io,
  input  logic       pg_ana,
  input  logic       pg_logic,
  output logic       io_en,
  output logic       ana_en,
  output logic       logic_en,
  output logic       ready,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [3:0] {
    StOff,
    StUpIo,
    StUpAna,
    StUpLogic,
    StOn,
    StDownLogic,
    StDownAna,
    StDownIo,
    StFault
`ifdef LDO_SEQ_RETRY_EN
    , StRetry
`endif
  } state_e;

  localparam logic [1:0] CodeNone  = 2'd0;
  localparam logic [1:0] CodeIo    = 2'd1;
  localparam logic [1:0] CodeAna   = 2'd2;
  localparam logic [1:0] CodeLogic = 2'd3;

  localparam logic [CNT_W-1:0] StepLast    = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(PG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OffLast     = CNT_W'(OFF_DLY - 1);

  if (STEP_DLY < 1) begin : g_bad_step
    $error("STEP_DLY must be at least 1");
  end
  if (OFF_DLY < 1) begin : g_bad_off
    $error("OFF_DLY must be at least 1");
  end
  if (PG_TIMEOUT <= STEP_DLY || PG_TIMEOUT > (2 ** CNT_W) - 1) begin : g_bad_timeout
    $error("PG_TIMEOUT must exceed STEP_DLY and fit in the counter");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       code_d;
  logic             up_fault;
  logic [1:0]       up_code;
  logic             pg_timeout;
  logic             step_done;
  logic             off_done;

`ifdef LDO_SEQ_RETRY_EN
  logic retry_q, retry_d;
`endif

  assign pg_timeout = (cnt_q == TimeoutLast);
  assign step_done  = (cnt_q >= StepLast);
  assign off_done   = (cnt_q == OffLast);

  always_comb begin
    state_d  = state_q;
    code_d   = fault_code;
    up_fault = 1'b0;
    up_code  = CodeNone;
`ifdef LDO_SEQ_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      StOff: begin
        code_d = CodeNone;
`ifdef LDO_SEQ_RETRY_EN
        retry_d = 1'b0;
`endif
        if (start && !stop) state_d = StUpIo;
      end
      StUpIo: begin
        if (pg_timeout && !pg_io) begin
          up_fault = 1'b1;
          up_code  = CodeIo;
        end else if (stop) begin
          state_d = StDownIo;
        end else if (pg_io && step_done) begin
          state_d = StUpAna;
        end
      end
      StUpAna: begin
        // Earlier rails are checked before the rail currently ramping.
        if (!pg_io) begin
          up_fault = 1'b1;
          up_code  = CodeIo;
        end else if (pg_timeout && !pg_ana) begin
          up_fault = 1'b1;
          up_code  = CodeAna;
        end else if (stop) begin
          state_d = StDownAna;
        end else if (pg_ana && step_done) begin
          state_d = StUpLogic;
        end
      end
      StUpLogic: begin
        if (!pg_io) begin
          up_fault = 1'b1;
          up_code  = CodeIo;
        end else if (!pg_ana) begin
          up_fault = 1'b1;
          up_code  = CodeAna;
        end else if (pg_timeout && !pg_logic) begin
          up_fault = 1'b1;
          up_code  = CodeLogic;
        end else if (stop) begin
          state_d = StDownLogic;
        end else if (pg_logic && step_done) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (!pg_io || !pg_ana || !pg_logic) begin
          state_d = StFault;
          code_d  = !pg_io ? CodeIo : (!pg_ana ? CodeAna : CodeLogic);
        end else if (stop) begin
          state_d = StDownLogic;
        end
      end
      StDownLogic: if (off_done) state_d = StDownAna;
      StDownAna:   if (off_done) state_d = StDownIo;
      StDownIo:    if (off_done) state_d = StOff;
      StFault: begin
        if (clear_fault && !start) begin
          state_d = StOff;
          code_d  = CodeNone;
        end
      end
`ifdef LDO_SEQ_RETRY_EN
      StRetry: begin
        if (stop) state_d = StOff;
        else if (off_done) state_d = StUpIo;
      end
`endif
      default: state_d = StOff;
    endcase

    if (up_fault) begin
`ifdef LDO_SEQ_RETRY_EN
      if (!retry_q) begin
        state_d = StRetry;
        retry_d = 1'b1;
      end else begin
        state_d = StFault;
        code_d  = up_code;
      end
`else
      state_d = StFault;
      code_d  = up_code;
`endif
    end

`ifdef LDO_SEQ_RETRY_EN
    if (state_d == StOn) retry_d = 1'b0;
`endif
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StOff;
      cnt_q      <= '0;
      io_en      <= 1'b0;
      ana_en     <= 1'b0;
      logic_en   <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      fault_code <= CodeNone;
    end else begin
      state_q    <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
      io_en      <= state_d inside {StUpIo, StUpAna, StUpLogic, StOn, StDownLogic, StDownAna};
      ana_en     <= state_d inside {StUpAna, StUpLogic, StOn, StDownLogic};
      logic_en   <= state_d inside {StUpLogic, StOn};
      ready      <= (state_d == StOn);
      fault      <= (state_d == StFault);
      fault_code <= code_d;
    end
  end

`ifdef LDO_SEQ_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_q <= 1'b0;
    else       retry_q <= retry_d;
  end
`endif

`ifndef SYNTHESIS
  a_ana_needs_io: assert property (@(posedge clk) disable iff (reset) ana_en |-> io_en);
  a_logic_needs_ana: assert property (@(posedge clk) disable iff (reset) logic_en |-> ana_en);
  a_ready_all_on: assert property (@(posedge clk) disable iff (reset) ready |-> logic_en);
  a_fault_all_off: assert property (@(posedge clk) disable iff (reset) fault |-> !io_en);
`endif

endmodule

// File: tb/tb_ldo_rail_sequencer.sv
// Scoreboard bench for ldo_rail_sequencer: expected output changes are queued with the edge
// they must appear on; a negedge monitor pops and checks each change the DUT makes.
module tb_ldo_rail_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start, stop, clear_fault, pg_io, pg_ana, pg_logic;
  logic       io_en, ana_en, logic_en, ready, fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_fails  = 0;
  int edge_cnt = 0;

  int         exp_edge[$];
  logic [6:0] exp_val[$];
  string      exp_tag[$];

  logic [6:0] outs;
  logic [6:0] prev_outs = '0;
  int         m_edge;
  logic [6:0] m_val;
  string      m_tag;

  // {io_en, ana_en, logic_en, ready, fault, fault_code}
  localparam logic [6:0] OutOff    = 7'b000_0_0_00;
  localparam logic [6:0] OutIo     = 7'b100_0_0_00;
  localparam logic [6:0] OutIoAna  = 7'b110_0_0_00;
  localparam logic [6:0] OutAll    = 7'b111_0_0_00;
  localparam logic [6:0] OutOn     = 7'b111_1_0_00;
  localparam logic [6:0] OutFltIo  = 7'b000_0_1_01;
  localparam logic [6:0] OutFltAna = 7'b000_0_1_10;
  localparam logic [6:0] OutFltLog = 7'b000_0_1_11;

  assign outs = {io_en, ana_en, logic_en, ready, fault, fault_code};

  ldo_rail_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear_fault(clear_fault),
    .pg_io      (pg_io),
    .pg_ana     (pg_ana),
    .pg_logic   (pg_logic),
    .io_en      (io_en),
    .ana_en     (ana_en),
    .logic_en   (logic_en),
    .ready      (ready),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (outs !== prev_outs) begin
      n_checks++;
      if (exp_val.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_change: outs=%b at edge %0d, required to stay %b",
                 outs, edge_cnt, prev_outs);
      end else begin
        m_edge = exp_edge.pop_front();
        m_val  = exp_val.pop_front();
        m_tag  = exp_tag.pop_front();
        if (outs !== m_val || edge_cnt != m_edge) begin
          n_fails++;
          $display("FAIL %s: outs=%b at edge %0d, required %b at edge %0d",
                   m_tag, outs, edge_cnt, m_val, m_edge);
        end
      end
      prev_outs = outs;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) step(1);
  endtask

  task automatic expect_at(input int e, input logic [6:0] v, input string tag);
    exp_edge.push_back(e);
    exp_val.push_back(v);
    exp_tag.push_back(tag);
  endtask

  task automatic check_now(input string tag, input logic [6:0] v);
    n_checks++;
    if (outs !== v) begin
      n_fails++;
      $display("FAIL %s: outs=%b, required %b", tag, outs, v);
    end
  endtask

  task automatic start_pulse(output int e);
    start = 1'b1;
    e = edge_cnt + 1;
    step(1);
    start = 1'b0;
  endtask

  task automatic expect_power_up(input int e, input string tag);
    expect_at(e,      OutIo,    {tag, "_io_en"});
    expect_at(e + 20, OutIoAna, {tag, "_ana_en"});
    expect_at(e + 40, OutAll,   {tag, "_logic_en"});
    expect_at(e + 60, OutOn,    {tag, "_ready"});
  endtask

  task automatic clear_at(input int c);
    wait_edge(c - 1);
    clear_fault = 1'b1;
    expect_at(c, OutOff, "clear_fault_to_off");
    step(1);
    clear_fault = 1'b0;
  endtask

  initial begin
    int e;
    int s;
    start = 1'b0; stop = 1'b0; clear_fault = 1'b0;
    pg_io = 1'b1; pg_ana = 1'b1; pg_logic = 1'b1;
    #1 reset = 1'b1;
    step(3);
    check_now("reset_state", OutOff);
    reset = 1'b0;
    step(2);

    // Clean power-up with all pg high.
    start_pulse(e);
    expect_power_up(e, "pu");

    // Stop in ON, with a start pulse during ramp-down that must be ignored.
    s = e + 70;
    wait_edge(s - 1);
    stop = 1'b1;
    expect_at(s,      OutIoAna, "stop_on_logic_off");
    expect_at(s + 10, OutIo,    "stop_on_ana_off");
    expect_at(s + 20, OutOff,   "stop_on_io_off");
    step(1);
    stop = 1'b0;
    wait_edge(s + 2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_edge(s + 35);

    // Analog power-good never rises.
    pg_ana = 1'b0;
    start_pulse(e);
    expect_at(e,      OutIo,    "ana_to_io_en");
    expect_at(e + 20, OutIoAna, "ana_to_ana_en");
`ifdef LDO_SEQ_RETRY_EN
    expect_at(e + 70,  OutOff,    "ana_to_retry");
    expect_at(e + 80,  OutIo,     "ana_to_retry_io_en");
    expect_at(e + 100, OutIoAna,  "ana_to_retry_ana_en");
    expect_at(e + 150, OutFltAna, "ana_to_fault");
    clear_at(e + 161);
`else
    expect_at(e + 70, OutFltAna, "ana_to_fault");
    clear_at(e + 81);
`endif
    pg_ana = 1'b1;
    step(3);

    // Single-cycle IO glitch in ON; start and clear+start must not leave FAULT.
    start_pulse(e);
    expect_power_up(e, "glitch");
    s = e + 70;
    wait_edge(s - 1);
    pg_io = 1'b0;
    expect_at(s, OutFltIo, "on_pg_io_fault");
    step(1);
    pg_io = 1'b1;
    wait_edge(s + 4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_edge(s + 9);
    clear_fault = 1'b1;
    start = 1'b1;
    step(2);
    clear_fault = 1'b0;
    start = 1'b0;
    clear_at(s + 15);
    step(3);

    // start and stop together in OFF, then stop during UP_ANA.
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    step(2);
    start_pulse(e);
    expect_at(e,      OutIo,    "abort_io_en");
    expect_at(e + 20, OutIoAna, "abort_ana_en");
    wait_edge(e + 24);
    stop = 1'b1;
    expect_at(e + 25, OutIo,  "abort_ana_off");
    expect_at(e + 35, OutOff, "abort_io_off");
    step(1);
    stop = 1'b0;
    wait_edge(e + 50);

`ifdef LDO_SEQ_RETRY_EN
    // Logic pg low on the first attempt only: one retry then ON.
    pg_logic = 1'b0;
    start_pulse(e);
    expect_at(e,      OutIo,    "retry1_io_en");
    expect_at(e + 20, OutIoAna, "retry1_ana_en");
    expect_at(e + 40, OutAll,   "retry1_logic_en");
    expect_at(e + 90, OutOff,   "retry1_retry");
    expect_power_up(e + 100, "retry1_second");
    wait_edge(e + 95);
    pg_logic = 1'b1;
    wait_edge(e + 169);
    stop = 1'b1;
    expect_at(e + 170, OutIoAna, "retry1_logic_off");
    expect_at(e + 180, OutIo,    "retry1_ana_off");
    expect_at(e + 190, OutOff,   "retry1_io_off");
    step(1);
    stop = 1'b0;
    wait_edge(e + 205);

    // Logic pg low on both attempts.
    pg_logic = 1'b0;
    start_pulse(e);
    expect_at(e,       OutIo,     "retry2_io_en");
    expect_at(e + 20,  OutIoAna,  "retry2_ana_en");
    expect_at(e + 40,  OutAll,    "retry2_logic_en");
    expect_at(e + 90,  OutOff,    "retry2_retry");
    expect_at(e + 100, OutIo,     "retry2_io_en_again");
    expect_at(e + 120, OutIoAna,  "retry2_ana_en_again");
    expect_at(e + 140, OutAll,    "retry2_logic_en_again");
    expect_at(e + 190, OutFltLog, "retry2_fault");
    clear_at(e + 201);
`else
    // Logic pg never rises.
    pg_logic = 1'b0;
    start_pulse(e);
    expect_at(e,      OutIo,     "logic_to_io_en");
    expect_at(e + 20, OutIoAna,  "logic_to_ana_en");
    expect_at(e + 40, OutAll,    "logic_to_logic_en");
    expect_at(e + 90, OutFltLog, "logic_to_fault");
    clear_at(e + 101);
`endif
    pg_logic = 1'b1;
    step(3);

    // Asynchronous reset while in UP_LOGIC.
    start_pulse(e);
    expect_at(e,      OutIo,    "rst_io_en");
    expect_at(e + 20, OutIoAna, "rst_ana_en");
    expect_at(e + 40, OutAll,   "rst_logic_en");
    wait_edge(e + 45);
    #1;
    reset = 1'b1;
    expect_at(e + 45, OutOff, "rst_async_off");
    #1;
    check_now("rst_immediate", OutOff);
    step(2);
    reset = 1'b0;
    step(5);

    n_checks++;
    if (exp_val.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: %0d expected changes never seen (first %s), required 0",
               exp_val.size(), exp_tag[0]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
